md_sequencer: RTL and testbench
===============================

# md_sequencer

Multiply/divide sequencer for the pipelined MIPS core's HI/LO resource, sitting beside the E-stage ALU. It accepts mult/multu/div/divu issues and mthi/mtlo writes from E, models the fixed multi-cycle latency with a counter-driven FSM, and commits results to HI/LO at completion. It also drives the D-stage stall for any HI/LO-relative instruction that arrives while an operation is issuing or in flight.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage issue strobe for a mult/div op
- op  in  2  0 mult, 1 multu, 2 div, 3 divu; sampled with start
- in1  in  32  rs operand, already forwarded
- in2  in  32  rt operand, already forwarded
- mt_we  in  1  E-stage mthi/mtlo write
- mt_sel  in  1  0 selects LO, 1 selects HI
- mt_data  in  32  value for mthi/mtlo
- md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- stall  out  1  combinational: md_use_D & (start | busy)
- done  out  1  one-cycle pulse after a commit
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE, BUSY.
- IDLE, start=1 at edge N:
  - latch the op result into pend_hi/pend_lo;
  - load cnt = latency − 1;
  - go to BUSY.
- BUSY:
  - cnt decrements each edge.
  - At the edge where cnt==0: hi/lo ← pend_hi/pend_lo, state → IDLE, done=1 for the following cycle.
- Arithmetic:
  - mult: signed 32×32 → 64; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / −1 gives LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
- Divide by zero: full DIV_CYCLES busy period; HI/LO keep their prior values; done still pulses.
- mt_we in IDLE with start=0: the selected register is written at the next edge; busy is not asserted.
- Simultaneous events:
  - start and mt_we together: start wins, mt_we ignored.
  - start while BUSY: ignored. Pipeline stall makes this illegal; the bench flags it.
  - mt_we while BUSY: ignored. Also illegal.
- hi/lo change only at commit, on an mt write, or at reset.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state IDLE, cnt=0, pend_*=0. stall follows its inputs.
- Reset mid-operation: the operation is discarded, HI/LO go to 0 immediately, done does not pulse.
- Issue at edge N:
  - busy=1 in cycles N+1 … N+L, where L is the op latency;
  - HI/LO new values visible from cycle N+L+1;
  - busy=0 and done=1 in cycle N+L+1.
- stall is high in the issue cycle itself (start) and in every busy cycle, so mfhi/mflo in D reads committed HI/LO.
- mt write at edge N is visible on hi/lo from cycle N+1.
- Back-to-back issue is allowed in the first IDLE cycle after completion.

## Structure
- Shared package md_pkg holds:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - state encoding;
  - default latency constants.
- One natural sub-module, md_arith: combinational 64-bit product, quotient/remainder, and the div-by-zero flag. It is instantiated once; md_sequencer holds the FSM, counter, pending and architectural registers.

## Test plan
- mult: in1=0xFFFFFFFE (−2), in2=3 → busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; done pulses once.
- divu: in1=7, in2=2 → busy for 10 cycles; LO=3, HI=1. div: in1=−7, in2=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div by zero with HI=0x11, LO=0x22 preset via mthi/mtlo → busy for 10 cycles; HI/LO unchanged; done=1.
- md_use_D=1 held through a mult → stall=1 on the issue cycle plus 5 busy cycles, 0 afterwards; md_use_D=0 → stall=0 throughout.
- Assert reset in the 3rd busy cycle of a div → busy, hi and lo read 0 immediately; no done pulse; next issue behaves normally.
- start and mt_we in the same cycle (mt_sel=1, mt_data=0xAB) → mult result committed, HI ≠ 0xAB. A back-to-back mult in the first cycle after done is accepted.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds op encodings, FSM state encoding and default latencies.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath: 64-bit product, quotient/remainder
// and div-by-zero flag.
// Ports: op, in1, in2 in; res_hi, res_lo, div_zero out.
import md_pkg::*;

module md_arith (
    input  logic [1:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        sgn;
    logic        is_div;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dvsr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    // mult and div are the signed variants (op[0] == 0)
    assign sgn    = ~op[0];
    assign is_div = op[1];

    always_comb begin
        a_ext = sgn ? {{32{in1[31]}}, in1} : {32'b0, in1};
        b_ext = sgn ? {{32{in2[31]}}, in2} : {32'b0, in2};
        // low 64 bits of the product are correct for both signednesses
        prod  = a_ext * b_ext;
    end

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to
    // 0x80000000 with remainder 0 instead of overflowing.
    always_comb begin
        mag_a = (sgn && in1[31]) ? -in1 : in1;
        mag_b = (sgn && in2[31]) ? -in2 : in2;
        dvsr  = (in2 == 32'd0) ? 32'd1 : mag_b;
        uq    = mag_a / dvsr;
        ur    = mag_a % dvsr;
        quo   = (sgn && (in1[31] ^ in2[31])) ? -uq : uq;
        rem   = (sgn && in1[31]) ? -ur : ur;
    end

    assign res_hi   = is_div ? rem : prod[63:32];
    assign res_lo   = is_div ? quo : prod[31:0];
    assign div_zero = is_div && (in2 == 32'd0);

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: fixed-latency FSM, HI/LO registers,
// mthi/mtlo writes and D-stage stall generation.
// Ports: clk, reset, start, op, in1, in2, mt_we, mt_sel, mt_data,
//   md_use_D in; busy, stall, done, hi, lo out.
import md_pkg::*;

module md_sequencer #(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int LMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES
                                                     : DIV_CYCLES;
    localparam int CW   = (LMAX > 1) ? $clog2(LMAX) : 1;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          pend_dz_q, pend_dz_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          done_q, done_d;

    logic [31:0] ar_hi;
    logic [31:0] ar_lo;
    logic        ar_dz;

    md_arith u_arith (
        .op       (op),
        .in1      (in1),
        .in2      (in2),
        .res_hi   (ar_hi),
        .res_lo   (ar_lo),
        .div_zero (ar_dz)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // start has priority over a same-cycle mt write
                if (start) begin
                    state_d   = ST_BUSY;
                    cnt_d     = op[1] ? DIV_LOAD : MULT_LOAD;
                    pend_hi_d = ar_hi;
                    pend_lo_d = ar_lo;
                    pend_dz_d = ar_dz;
                end else if (mt_we) begin
                    if (mt_sel) hi_d = mt_data;
                    else        lo_d = mt_data;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    // divide by zero leaves HI/LO untouched
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_dz_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy  = (state_q == ST_BUSY);
    assign stall = md_use_D & (start | busy);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer using a commit scoreboard.
// Ports: none (top-level bench).
module tb_md_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    typedef struct {
        logic [63:0] hl;
        int          lat;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        mt_we = 1'b0;
    logic        mt_sel = 1'b0;
    logic [31:0] mt_data = '0;
    logic        md_use_D = 1'b0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    sb_t sb[$];
    logic [63:0] model_hl = '0;
    int busy_run = 0;
    logic prev_done = 1'b0;

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .in1      (in1),
        .in2      (in2),
        .mt_we    (mt_we),
        .mt_sel   (mt_sel),
        .mt_data  (mt_data),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [1:0] o,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [63:0] prev);
        longint sa, sb_, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb_ = $signed(b);
        case (o)
            2'd0: begin p = sa * sb_; return p; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; return p; end
            2'd2: begin
                if (b == 0) return prev;
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return prev;
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Commit monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (reset) begin
            busy_run = 0;
            prev_done = 1'b0;
            sb.delete();
        end else begin
            if (busy && (start || mt_we))
                chk("illegal_issue_while_busy", 1, 0);
            if (done && prev_done)
                chk("done_single_pulse", 1, 0);
            if (busy) begin
                busy_run++;
            end else if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("commit_hi", hi, e.hl[63:32]);
                    chk("commit_lo", lo, e.hl[31:0]);
                    chk("busy_len", busy_run, e.lat);
                end
                busy_run = 0;
            end else begin
                busy_run = 0;
            end
            prev_done = done;
        end
    end

    // Caller must be between edges; start is sampled at the next posedge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic use_d,
                         input logic with_mt);
        sb_t e;
        e.hl = ref_md(o, a, b, model_hl);
        e.lat = o[1] ? DC : MC;
        model_hl = e.hl;
        sb.push_back(e);
        start = 1'b1;
        op = o;
        in1 = a;
        in2 = b;
        md_use_D = use_d;
        mt_we = with_mt;
        mt_sel = 1'b1;
        mt_data = 32'hAB;
        #1;
        chk("stall_issue_cycle", stall, use_d);
        @(posedge clk);
        #1;
        start = 1'b0;
        mt_we = 1'b0;
    endtask

    task automatic wait_done(input logic use_d, input int lat);
        int n = 0;
        int st = 0;
        logic got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
            else if (stall) st++;
        end
        if (!got) chk("done_timeout", 0, 1);
        chk("stall_busy_cycles", st, use_d ? lat : 0);
        md_use_D = 1'b0;
    endtask

    task automatic mt_write(input logic sel, input logic [31:0] d);
        mt_we = 1'b1;
        mt_sel = sel;
        mt_data = d;
        if (sel) model_hl[63:32] = d;
        else     model_hl[31:0] = d;
        @(posedge clk);
        #1;
        mt_we = 1'b0;
        @(negedge clk);
        chk("mt_no_busy", busy, 0);
        chk(sel ? "mt_hi" : "mt_lo", sel ? hi : lo, d);
    endtask

    initial begin
        int dn;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        #1 reset = 1'b0;
        @(negedge clk);

        issue(2'd0, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
        wait_done(1'b1, MC);
        chk("mult_neg_hi", hi, 32'hFFFFFFFF);
        chk("mult_neg_lo", lo, 32'hFFFFFFFA);

        issue(2'd3, 32'd7, 32'd2, 1'b0, 1'b0);
        wait_done(1'b0, DC);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        issue(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        wait_done(1'b0, DC);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);

        mt_write(1'b1, 32'h11);
        mt_write(1'b0, 32'h22);
        issue(2'd2, 32'd100, 32'd0, 1'b1, 1'b0);
        wait_done(1'b1, DC);
        chk("divz_hi", hi, 32'h11);
        chk("divz_lo", lo, 32'h22);

        issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        wait_done(1'b0, DC);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'd0);

        issue(2'd0, 32'h1234, 32'h5678, 1'b0, 1'b0);
        wait_done(1'b0, MC);

        // reset during the third busy cycle of a div
        issue(2'd3, 32'd1000, 32'd7, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        model_hl = '0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("midrst_no_done", dn, 0);

        issue(2'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
        wait_done(1'b1, MC);

        issue(2'd0, 32'd5, 32'd7, 1'b0, 1'b1);
        wait_done(1'b0, MC);
        chk("start_beats_mt_hi", hi, 32'd0);
        chk("start_beats_mt_lo", lo, 32'd35);

        // back-to-back issue in the done cycle
        issue(2'd0, 32'hFFFF0000, 32'h00010001, 1'b0, 1'b0);
        wait_done(1'b0, MC);
        issue(2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0);
        wait_done(1'b0, MC);
        chk("b2b_hi", hi, 32'h3FFFFFFF);
        chk("b2b_lo", lo, 32'h00000001);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
